// File: rtl/enc_pkg.sv
// Shared types and helpers for the serial priority encoder.
// clog2_min1 keeps index ports at least one bit wide.
package enc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// Combinational priority encoder: index of the highest (or lowest) set bit,
// plus any-bit-set and more-than-one-bit-set flags.
module prio_enc_comb
  import enc_pkg::*;
#(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic [N-1:0]                vec,
  output logic [clog2_min1(N)-1:0]    idx,
  output logic                        any,
  output logic                        multi
);

  localparam int W = clog2_min1(N);

  // Later iterations override earlier ones, so the scan direction sets priority.
  always_comb begin
    idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < N; i++) begin
        if (vec[i]) idx = W'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (vec[i]) idx = W'(i);
      end
    end
  end

  assign any   = |vec;
  assign multi = |(vec & (vec - N'(1)));

endmodule

// File: rtl/prio_encoder_serial.sv
// Serial priority encoder: accepts an N-bit request vector and drains one
// encoded index per beat for every set bit, in priority order.
//
// state | meaning
// IDLE  | in_ready high, waiting for a request vector
// DRAIN | one beat per set bit of pend; leaves after the last beat transfers
module prio_encoder_serial
  import enc_pkg::*;
#(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N-1:0]              in_vec,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [clog2_min1(N)-1:0]  out_idx,
  output logic                      out_last,
  output logic                      out_none,
  output logic                      out_multi
);

  localparam int W = clog2_min1(N);

  state_t       state, state_nxt;
  logic [N-1:0] pend, pend_nxt;
  logic         multi_q, none_q;
  logic [W-1:0] pend_idx, in_idx_unused;
  logic         pend_any_unused, pend_multi;
  logic         in_any, in_multi;
  logic         accept, beat, last;

  prio_enc_comb #(.N(N), .MSB_FIRST(MSB_FIRST)) u_in_enc (
    .vec   (in_vec),
    .idx   (in_idx_unused),
    .any   (in_any),
    .multi (in_multi)
  );

  prio_enc_comb #(.N(N), .MSB_FIRST(MSB_FIRST)) u_pend_enc (
    .vec   (pend),
    .idx   (pend_idx),
    .any   (pend_any_unused),
    .multi (pend_multi)
  );

  assign last   = ~pend_multi;
  assign accept = (state == IDLE) && in_valid;
  assign beat   = (state == DRAIN) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = DRAIN;
      DRAIN:   if (out_ready && last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // pend and the flags load only on accept, so in_vec is never sampled otherwise.
  always_comb begin
    pend_nxt = pend;
    if (accept)    pend_nxt = in_vec;
    else if (beat) pend_nxt = pend & ~(N'(1) << pend_idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= '0;
      multi_q <= 1'b0;
      none_q  <= 1'b0;
    end else begin
      pend <= pend_nxt;
      if (accept) begin
        multi_q <= in_multi;
        none_q  <= ~in_any;
      end
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_idx   = '0;
    out_last  = 1'b0;
    out_none  = 1'b0;
    out_multi = 1'b0;
    case (state)
      IDLE:  in_ready = 1'b1;
      DRAIN: begin
        out_valid = 1'b1;
        out_idx   = pend_idx;
        out_last  = last;
        out_none  = none_q;
        out_multi = multi_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_prio_encoder_serial.sv
// Bench for prio_encoder_serial: three instances (N=8 MSB-first, N=8 LSB-first,
// N=16 MSB-first) checked against a queue of expected beats.
module tb_prio_encoder_serial;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int idx;
    bit last;
    bit multi;
    bit none;
  } beat_t;

  beat_t exp_q[$];

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_out_none, a_out_multi;
  logic [7:0] a_in_vec;
  logic [2:0] a_out_idx;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_out_none, b_out_multi;
  logic [7:0] b_in_vec;
  logic [2:0] b_out_idx;

  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_last, c_out_none, c_out_multi;
  logic [15:0] c_in_vec;
  logic [3:0]  c_out_idx;

  prio_encoder_serial #(.N(8), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_vec(a_in_vec),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_idx(a_out_idx), .out_last(a_out_last),
    .out_none(a_out_none), .out_multi(a_out_multi)
  );

  prio_encoder_serial #(.N(8), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_vec(b_in_vec),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_idx(b_out_idx), .out_last(b_out_last),
    .out_none(b_out_none), .out_multi(b_out_multi)
  );

  prio_encoder_serial #(.N(16), .MSB_FIRST(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_vec(c_in_vec),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_idx(c_out_idx), .out_last(c_out_last),
    .out_none(c_out_none), .out_multi(c_out_multi)
  );

  // Reference model: list set bits in drain order.
  function automatic void push_expected(input logic [15:0] vec, input int n, input bit msb_first);
    int    cnt;
    int    seen;
    int    i;
    beat_t b;
    cnt  = 0;
    seen = 0;
    for (int k = 0; k < n; k++) if (vec[k]) cnt++;
    if (cnt == 0) begin
      b.idx = 0; b.last = 1'b1; b.multi = 1'b0; b.none = 1'b1;
      exp_q.push_back(b);
      return;
    end
    for (int k = 0; k < n; k++) begin
      i = msb_first ? (n - 1 - k) : k;
      if (vec[i]) begin
        seen++;
        b.idx = i; b.last = (seen == cnt); b.multi = (cnt > 1); b.none = 1'b0;
        exp_q.push_back(b);
      end
    end
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    a_in_valid = 0; a_in_vec = '0; a_out_ready = 0;
    b_in_valid = 0; b_in_vec = '0; b_out_ready = 0;
    c_in_valid = 0; c_in_vec = '0; c_out_ready = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b, expected 1 0", a_in_ready, a_out_valid);
    end
    n_checks++;
    if (a_out_idx !== 3'd0 || a_out_last !== 1'b0 || a_out_none !== 1'b0 || a_out_multi !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outs: idx=%0d last=%b none=%b multi=%b, expected all 0",
               a_out_idx, a_out_last, a_out_none, a_out_multi);
    end
    n_checks++;
    if (b_in_ready !== 1'b1 || c_in_ready !== 1'b1 || b_out_valid !== 1'b0 || c_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_others: b_ready=%b c_ready=%b b_valid=%b c_valid=%b, expected 1 1 0 0",
               b_in_ready, c_in_ready, b_out_valid, c_out_valid);
    end
  endtask

  // One-hot, multi-hot, zero, all-ones and a random vector on the MSB-first N=8 instance.
  task automatic test_vectors_msb();
    logic [7:0] vecs[5];
    beat_t      e;
    int         cyc;
    vecs = '{8'h04, 8'h92, 8'h00, 8'hFF, 8'h00};
    vecs[4] = 8'($urandom_range(1, 255));
    for (int v = 0; v < 5; v++) begin
      exp_q.delete();
      @(negedge clk);
      n_checks++;
      if (a_in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL vec_idle_ready: in_ready=%b, expected 1 (vec %h)", a_in_ready, vecs[v]);
      end
      push_expected({8'h00, vecs[v]}, 8, 1'b1);
      a_in_vec = vecs[v]; a_in_valid = 1'b1; a_out_ready = 1'b1;
      @(negedge clk);
      a_in_valid = 1'b0; a_in_vec = 'x;
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 40) begin
        e = exp_q[0];
        n_checks++;
        if (a_out_valid !== 1'b1 || a_out_idx !== 3'(e.idx) || a_out_last !== e.last ||
            a_out_multi !== e.multi || a_out_none !== e.none || a_in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL vec_beat %h: valid=%b idx=%0d last=%b multi=%b none=%b rdy=%b, expected 1 %0d %b %b %b 0",
                   vecs[v], a_out_valid, a_out_idx, a_out_last, a_out_multi, a_out_none, a_in_ready,
                   e.idx, e.last, e.multi, e.none);
        end
        void'(exp_q.pop_front());
        @(negedge clk);
        cyc++;
      end
      n_checks++;
      if (exp_q.size() != 0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL vec_done %h: left=%0d out_valid=%b in_ready=%b, expected 0 0 1",
                 vecs[v], exp_q.size(), a_out_valid, a_in_ready);
      end
    end
  endtask

  // LSB-first with back-pressure: beats must hold steady across stalls.
  task automatic test_lsb_stall();
    bit    pat[5];
    beat_t e;
    int    cyc;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_q.delete();
    push_expected(16'h0092, 8, 1'b0);
    @(negedge clk);
    b_in_vec = 8'h92; b_in_valid = 1'b1; b_out_ready = pat[0];
    @(negedge clk);
    b_in_valid = 1'b0;
    cyc = 1;
    while (exp_q.size() > 0 && cyc < 40) begin
      e = exp_q[0];
      b_in_vec = 8'($urandom_range(0, 255));
      n_checks++;
      if (b_out_valid !== 1'b1 || b_out_idx !== 3'(e.idx) || b_out_last !== e.last ||
          b_out_multi !== e.multi || b_out_none !== e.none || b_in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL lsb_beat cyc%0d: valid=%b idx=%0d last=%b multi=%b none=%b rdy=%b, expected 1 %0d %b %b %b 0",
                 cyc, b_out_valid, b_out_idx, b_out_last, b_out_multi, b_out_none, b_in_ready,
                 e.idx, e.last, e.multi, e.none);
      end
      b_out_ready = (cyc < 5) ? pat[cyc] : 1'b1;
      if (b_out_ready) void'(exp_q.pop_front());
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (exp_q.size() != 0 || b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || cyc != 6) begin
      n_fail++;
      $display("FAIL lsb_done: left=%0d out_valid=%b in_ready=%b cycles=%0d, expected 0 0 1 6",
               exp_q.size(), b_out_valid, b_in_ready, cyc);
    end
  endtask

  // N=16 all-ones full drain, then a second drain cut by reset after 5 beats.
  task automatic test_all_ones_reset();
    beat_t e;
    int    cyc;
    int    done;
    bit    hit_reset;
    for (int pass = 0; pass < 2; pass++) begin
      exp_q.delete();
      push_expected(16'hFFFF, 16, 1'b1);
      @(negedge clk);
      c_in_vec = 16'hFFFF; c_in_valid = 1'b1; c_out_ready = 1'b1;
      @(negedge clk);
      c_in_valid = 1'b0;
      cyc = 0; done = 0; hit_reset = 1'b0;
      while (exp_q.size() > 0 && cyc < 40) begin
        e = exp_q[0];
        n_checks++;
        if (c_out_valid !== 1'b1 || c_out_idx !== 4'(e.idx) || c_out_last !== e.last ||
            c_out_multi !== e.multi || c_out_none !== e.none) begin
          n_fail++;
          $display("FAIL ones_beat p%0d: valid=%b idx=%0d last=%b multi=%b none=%b, expected 1 %0d %b %b %b",
                   pass, c_out_valid, c_out_idx, c_out_last, c_out_multi, c_out_none,
                   e.idx, e.last, e.multi, e.none);
        end
        if (pass == 1 && done == 5) begin
          #2 rst_n = 1'b0;
          #1;
          hit_reset = 1'b1;
          n_checks++;
          if (c_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async_valid: out_valid=%b, expected 0", c_out_valid);
          end
          break;
        end
        void'(exp_q.pop_front());
        done++;
        @(negedge clk);
        cyc++;
      end
      if (pass == 0) begin
        n_checks++;
        if (exp_q.size() != 0 || done != 16 || c_out_valid !== 1'b0 || c_in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL ones_done: left=%0d beats=%0d out_valid=%b in_ready=%b, expected 0 16 0 1",
                   exp_q.size(), done, c_out_valid, c_in_ready);
        end
      end else begin
        n_checks++;
        if (!hit_reset) begin
          n_fail++;
          $display("FAIL rst_reached: beats=%0d, expected reset after 5", done);
        end
      end
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (c_in_ready !== 1'b1 || c_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_release: in_ready=%b out_valid=%b, expected 1 0", c_in_ready, c_out_valid);
    end
    // A one-hot afterwards must yield a single clean beat, proving pend was flushed.
    push_expected(16'h0100, 16, 1'b1);
    c_in_vec = 16'h0100; c_in_valid = 1'b1;
    @(negedge clk);
    c_in_valid = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (c_out_valid !== 1'b1 || c_out_idx !== 4'(e.idx) || c_out_last !== e.last || c_out_multi !== e.multi) begin
      n_fail++;
      $display("FAIL rst_flush_beat: valid=%b idx=%0d last=%b multi=%b, expected 1 %0d %b %b",
               c_out_valid, c_out_idx, c_out_last, c_out_multi, e.idx, e.last, e.multi);
    end
    @(negedge clk);
    n_checks++;
    if (c_out_valid !== 1'b0 || c_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_flush_done: out_valid=%b in_ready=%b, expected 0 1", c_out_valid, c_in_ready);
    end
  endtask

  // in_valid held high: second vector accepted one cycle after the first vector's last transfer.
  task automatic test_back_to_back();
    beat_t e;
    exp_q.delete();
    push_expected(16'h0001, 8, 1'b1);
    push_expected(16'h0080, 8, 1'b1);
    @(negedge clk);
    a_in_vec = 8'h01; a_in_valid = 1'b1; a_out_ready = 1'b1;
    @(negedge clk);
    a_in_vec = 8'h80;
    e = exp_q.pop_front();
    n_checks++;
    if (a_out_valid !== 1'b1 || a_out_idx !== 3'(e.idx) || a_out_last !== e.last || a_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first: valid=%b idx=%0d last=%b rdy=%b, expected 1 %0d %b 0",
               a_out_valid, a_out_idx, a_out_last, a_in_ready, e.idx, e.last);
    end
    @(negedge clk);
    n_checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_gap: out_valid=%b in_ready=%b, expected 0 1", a_out_valid, a_in_ready);
    end
    @(negedge clk);
    a_in_valid = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (a_out_valid !== 1'b1 || a_out_idx !== 3'(e.idx) || a_out_last !== e.last ||
        a_out_multi !== e.multi || a_out_none !== e.none) begin
      n_fail++;
      $display("FAIL b2b_second: valid=%b idx=%0d last=%b multi=%b none=%b, expected 1 %0d %b %b %b",
               a_out_valid, a_out_idx, a_out_last, a_out_multi, a_out_none, e.idx, e.last, e.multi, e.none);
    end
    @(negedge clk);
    n_checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_done: out_valid=%b in_ready=%b, expected 0 1", a_out_valid, a_in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_vectors_msb();
    test_lsb_stall();
    test_all_ones_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
